// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DIV_FIX
  } state_e;

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module mips_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    // Top bit of diff set means the subtraction borrowed: restore.
    if (diff[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // opa holds the multiplicand or the quotient shift register; opb the multiplier or divisor.
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]   rem_q, rem_d, raw_q, raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               mul_signed_q, mul_signed_d;
  logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
  logic               busy_q;

  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic               div_signed;

  mips_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (opa_q),
    .dvs_i (opb_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Sign-extending to 2*WIDTH makes one unsigned multiply serve both MULT and MULTU.
  always_comb begin
    ext_a = {{WIDTH{mul_signed_q & opa_q[WIDTH-1]}}, opa_q};
    ext_b = {{WIDTH{mul_signed_q & opb_q[WIDTH-1]}}, opb_q};
    prod  = ext_a * ext_b;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rem_d        = rem_q;
    raw_d        = raw_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_signed_d = mul_signed_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    div0_d       = div0_q;
    div_signed   = (op == OP_DIV);

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              opa_d        = rs_val;
              opb_d        = rt_val;
              mul_signed_d = (op == OP_MULT);
              cnt_d        = CNT_W'(MUL_CYCLES - 1);
              state_d      = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              opa_d     = (div_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
              opb_d     = (div_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
              rem_d     = '0;
              raw_d     = rs_val;
              neg_quo_d = div_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_rem_d = div_signed && rs_val[WIDTH-1];
              div0_d    = (rt_val == '0);
              cnt_d     = CNT_W'(DIV_ITERS - 1);
              state_d   = S_DIV;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          opa_d = step_quo;
          if (cnt_q == '0) state_d = S_DIV_FIX;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          if (div0_q) begin
            lo_d = '1;
            hi_d = raw_q;
          end else begin
            lo_d = neg_quo_q ? -opa_q : opa_q;
            hi_d = neg_rem_q ? -rem_q : rem_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rem_q        <= '0;
      raw_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      div0_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rem_q        <= rem_d;
      raw_q        <= raw_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_signed_q <= mul_signed_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      div0_q       <= div0_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: driver pushes expected HI/LO/latency, monitor checks on busy fall.
module tb_mips_muldiv;

  localparam int unsigned MUL_CYCLES = 4;
  localparam int unsigned DIV_LAT    = 33;

  logic        clock = 1'b0;
  logic        reset_n, start, flush, busy;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  int          busy_cnt = 0;
  logic        prev_busy = 1'b0;

  mips_muldiv #(.MUL_CYCLES(MUL_CYCLES), .WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .flush   (flush),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic, updates the HI/LO model.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output exp_t e);
    longint          sa, sb_v, q, r;
    logic [63:0]     p;
    e.lat = 0;
    case (o)
      3'd0: begin
        sa = $signed(a); sb_v = $signed(b); p = sa * sb_v;
        hi_m = p[63:32]; lo_m = p[31:0]; e.lat = MUL_CYCLES;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        hi_m = p[63:32]; lo_m = p[31:0]; e.lat = MUL_CYCLES;
      end
      3'd2, 3'd3: begin
        e.lat = DIV_LAT;
        if (b == 0) begin
          lo_m = 32'hFFFF_FFFF; hi_m = a;
        end else begin
          if (o == 3'd2) begin sa = $signed(a); sb_v = $signed(b); end
          else begin sa = longint'({32'd0, a}); sb_v = longint'({32'd0, b}); end
          q = sa / sb_v; r = sa % sb_v;
          p = q; lo_m = p[31:0];
          p = r; hi_m = p[31:0];
        end
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
    e.hi = hi_m;
    e.lo = lo_m;
  endtask

  // Issue one op; optionally flush or poke another start after k busy cycles.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int flush_at, input int poke_at, input logic [2:0] poke_op);
    exp_t        e;
    logic [31:0] shi, slo;
    shi = hi_m;
    slo = lo_m;
    model_op(o, a, b, e);
    if (flush_at > 0) begin
      hi_m = shi; lo_m = slo;
      e.hi = shi; e.lo = slo; e.lat = flush_at;
    end
    if (o < 3'd4) sb.push_back(e);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= 200 && busy; k++) begin
      if (k == poke_at) begin
        start = 1'b1; op = poke_op; rs_val = $urandom; rt_val = $urandom;
      end
      if (k == flush_at) flush = 1'b1;
      @(negedge clock);
      start = 1'b0;
      flush = 1'b0;
    end
    check("busy_timeout", {31'd0, busy}, 32'd0);
    if (o >= 3'd4) begin
      check("direct_hi", hi, hi_m);
      check("direct_lo", lo, lo_m);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (busy) begin
      busy_cnt++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: busy fell with empty scoreboard");
      end else begin
        e = sb.pop_front();
        check("mon_hi", hi, e.hi);
        check("mon_lo", lo, e.lo);
        check("mon_busy_cycles", 32'(busy_cnt), 32'(e.lat));
      end
      busy_cnt = 0;
    end
    prev_busy = busy;
  end

  initial begin
    exp_t        e;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 3'd0);
    // Start during busy, including on the completion edge, must be ignored.
    run(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 2, 3'd0);
    run(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 3, 3'd4);
    run(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 32, 3'd5);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 3'd0);
    run(3'd3, 32'd100, 32'd0, 0, 0, 3'd0);
    run(3'd2, 32'hFFFF_FF00, 32'd0, 0, 0, 3'd0);
    run(3'd4, 32'h0000_1234, 32'd0, 0, 0, 3'd0);
    run(3'd5, 32'h0000_5678, 32'd0, 0, 0, 3'd0);
    run(3'd3, 32'd9, 32'd3, 10, 0, 3'd0);
    run(3'd0, 32'd7, 32'd6, 2, 0, 3'd0);
    run(3'd6, 32'hDEAD_BEEF, 32'd1, 0, 0, 3'd0);

    // Flush alongside a start in IDLE drops it, MTHI included.
    start = 1'b1; flush = 1'b1; op = 3'd4; rs_val = 32'hCAFE_F00D;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_busy", {31'd0, busy}, 32'd0);
    check("flush_idle_hi", hi, hi_m);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run(ro, ra, rb, 0, 0, 3'd0);
    end

    // Asynchronous reset mid-MULT.
    e.hi = '0; e.lo = '0; e.lat = 2;
    sb.push_back(e);
    hi_m = '0; lo_m = '0;
    start = 1'b1; op = 3'd0; rs_val = 32'd1234; rt_val = 32'd5678;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clock);
    run(3'd5, 32'hA5A5_A5A5, 32'd0, 0, 0, 3'd0);

    repeat (3) @(negedge clock);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Multi-cycle multiply/divide unit with the architectural HI/LO registers.
- Sits beside the EX stage of the pipelined MIPS core and consumes the rs/rt operands EX forwards to it.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and exposes HI/LO to the MFHI/MFLO datapath.
- Asserts busy so hazard control stalls any MFHI/MFLO or new mul/div until the result is written.

Parameters:
- MUL_CYCLES, 4, cycles busy is high for MULT/MULTU; legal range 1..8.
- WIDTH, 32, operand and HI/LO width; only 32 is verified.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  EX issues an op this cycle.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved.
- rs_val  input  32  forwarded rs: multiplicand, dividend, or MTHI/MTLO data.
- rt_val  input  32  forwarded rt: multiplier or divisor.
- flush  input  1  pipeline flush; aborts an in-flight op.
- busy  output  1  operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: reset_n low asynchronously forces state=IDLE, busy=0, hi=0, lo=0 and the counter to 0, including mid-operation.
- States:
  - IDLE.
  - MUL (counting).
  - DIV (one quotient bit per cycle).
  - DIV_FIX (sign correction and write-back).
- IDLE, start=1, flush=0:
  - op 0/1: latch operands, counter=MUL_CYCLES-1, go to MUL.
  - op 2/3: latch operand magnitudes and sign flags, counter=31, go to DIV.
  - op 4: hi<=rs_val at this edge, stay IDLE, busy stays 0.
  - op 5: lo<=rs_val at this edge, stay IDLE, busy stays 0.
  - op 6/7: no effect.
- busy is registered and equals (state!=IDLE).
  - MUL: busy high for exactly MUL_CYCLES cycles after the start edge.
  - DIV: busy high for exactly 33 cycles (32 in DIV, 1 in DIV_FIX).
- MUL: decrement the counter each cycle. At the edge where counter==0, {hi,lo}<=64-bit product and go to IDLE.
  - MULT uses a signed 32x32 product; MULTU an unsigned one.
  - The full 64-bit product is required.
- DIV: restoring division on magnitudes, one bit per cycle.
  - Counter==0 moves to DIV_FIX.
  - DIV_FIX writes lo=quotient, hi=remainder, then goes to IDLE.
  - Signed (DIV): negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=rs_val unchanged. Latency is still 33 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- start while busy: ignored. The hazard unit must not issue; the bench checks that state and hi/lo are unaffected.
- flush while busy: state->IDLE at the next edge, busy=0 the following cycle, hi/lo keep their pre-op values.
- flush with start in IDLE: the start is dropped, MTHI/MTLO included.
- Same-edge completion and start: the op completes, and a start with busy=1 is ignored. Issue resumes the cycle after busy falls.
- hi/lo change only at:
  - the MUL completion edge;
  - the DIV_FIX edge;
  - an MTHI/MTLO edge;
  - reset.

Decomposition:
- Package mips_muldiv_pkg:
  - op encodings (OP_MULT..OP_MTLO);
  - state enum (S_IDLE, S_MUL, S_DIV, S_DIV_FIX);
  - DIV_ITERS=32.
- Sub-module mips_div_step (combinational): one restoring step.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder and quotient.
- The FSM, counter, multiplier and HI/LO registers stay in mips_muldiv.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, MUL_CYCLES=4 -> busy high exactly 4 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. A start with op=MULT asserted during busy is ignored; result unchanged.
- DIV 0xFFFFFFF9 (-7) / 2 -> busy 33 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00000064.
- MTHI 0x1234, MTLO 0x5678 (no busy), then DIVU 9/3 with flush asserted on cycle 10 -> busy low the cycle after; hi=0x1234, lo=0x5678.
- reset_n pulled low mid-MULT (asynchronous, between edges) -> busy, hi, lo go to 0 immediately. After release, MTLO 0xA5A5A5A5 -> lo=0xA5A5A5A5 at the next edge.
